// File: rtl/text_memory_arbiter_pkg.sv
// Shared definitions for the text memory arbiter.
//   TEXT_BEGIN / TEXT_END : inclusive byte-address bounds of the text segment
//   port_e                : requester id carried through the in-flight register
//   rsp_tag_t             : in-flight response tag {valid, port, error}
package text_memory_arbiter_pkg;

  localparam logic [31:0] TEXT_BEGIN = 32'h0001_0000;
  localparam logic [31:0] TEXT_END   = 32'h0001_fffc;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  error;
  } rsp_tag_t;

endpackage

// File: rtl/text_request_checker.sv
// Combinational range/alignment check for one requester.
//   address : request byte address
//   word    : text memory word address derived from the byte address
//   error   : address outside [TEXT_BEGIN, TEXT_END] or not word aligned
module text_request_checker
  import text_memory_arbiter_pkg::*;
#(
  parameter int unsigned MEM_AWIDTH = 14
) (
  input  logic [31:0]           address,
  output logic [MEM_AWIDTH-1:0] word,
  output logic                  error
);

  assign word  = address[MEM_AWIDTH+1:2];
  assign error = (address < TEXT_BEGIN) || (address > TEXT_END) || (address[1:0] != 2'b00);

endmodule

// File: rtl/text_memory_arbiter.sv
// Shares the single-port synchronous-read text memory between instruction fetch
// (if_*) and data loads (dm_*). One grant per cycle, data has priority unless fetch
// has been starved for STARVE_LIMIT consecutive data grants. The response (or an
// error with zero data) returns on the issuing port one cycle after the handshake.
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   if_req_* / dm_req_*   : request handshakes (valid/ready/address)
//   if_rsp_* / dm_rsp_*   : single-cycle response pulses (valid/data/error)
//   mem_address, mem_q    : text memory word address out, read data in
module text_memory_arbiter
  import text_memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned MEM_AWIDTH   = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [31:0]           if_req_address,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_data,
  output logic                  if_rsp_error,
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic [31:0]           dm_req_address,
  output logic                  dm_rsp_valid,
  output logic [31:0]           dm_rsp_data,
  output logic                  dm_rsp_error,
  output logic [MEM_AWIDTH-1:0] mem_address,
  input  logic [31:0]           mem_q
);

  localparam int unsigned CntW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [MEM_AWIDTH-1:0] if_word, dm_word;
  logic                  if_error, dm_error;

  text_request_checker #(
    .MEM_AWIDTH (MEM_AWIDTH)
  ) u_if_check (
    .address (if_req_address),
    .word    (if_word),
    .error   (if_error)
  );

  text_request_checker #(
    .MEM_AWIDTH (MEM_AWIDTH)
  ) u_dm_check (
    .address (dm_req_address),
    .word    (dm_word),
    .error   (dm_error)
  );

  logic [CntW-1:0]       starve_cnt_q, starve_cnt_d;
  logic [MEM_AWIDTH-1:0] last_addr_q, last_addr_d;
  rsp_tag_t              pend_q, pend_d;
  logic                  if_grant, dm_grant, force_if;

  // Grants are gated by reset so neither port sees ready while reset is held.
  always_comb begin
    force_if = if_req_valid && (starve_cnt_q == Limit);
    dm_grant = !reset && dm_req_valid && !force_if;
    if_grant = !reset && if_req_valid && !dm_grant;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_valid || if_grant) begin
      starve_cnt_d = '0;
    end else if (dm_grant && (starve_cnt_q != Limit)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    last_addr_d  = last_addr_q;
    pend_d.valid = if_grant || dm_grant;
    pend_d.port  = dm_grant ? PORT_DM : PORT_IF;
    pend_d.error = dm_grant ? dm_error : if_error;
    if (dm_grant) begin
      last_addr_d = dm_word;
    end else if (if_grant) begin
      last_addr_d = if_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      last_addr_q  <= '0;
      pend_q       <= '{valid: 1'b0, port: PORT_IF, error: 1'b0};
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_addr_q  <= last_addr_d;
      pend_q       <= pend_d;
    end
  end

  // The address is driven combinationally so the memory samples it on the
  // handshake edge; with no grant the last address is held.
  always_comb begin
    mem_address  = last_addr_d;
    if_req_ready = if_grant;
    dm_req_ready = dm_grant;
    if_rsp_valid = pend_q.valid && (pend_q.port == PORT_IF);
    dm_rsp_valid = pend_q.valid && (pend_q.port == PORT_DM);
    if_rsp_error = if_rsp_valid && pend_q.error;
    dm_rsp_error = dm_rsp_valid && pend_q.error;
    if_rsp_data  = (if_rsp_valid && !pend_q.error) ? mem_q : 32'h0;
    dm_rsp_data  = (dm_rsp_valid && !pend_q.error) ? mem_q : 32'h0;
  end

endmodule

// File: tb/tb_text_memory_arbiter.sv
module tb_text_memory_arbiter;

  localparam logic [31:0] TB_BEGIN = 32'h0001_0000;
  localparam logic [31:0] TB_END   = 32'h0001_fffc;
  localparam int GNONE = 0;
  localparam int GIF   = 1;
  localparam int GDM   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0, dm_req_valid = 1'b0;
  logic [31:0] if_req_address = '0, dm_req_address = '0;
  logic        if_req_ready, dm_req_ready;
  logic        if_rsp_valid, dm_rsp_valid, if_rsp_error, dm_rsp_error;
  logic [31:0] if_rsp_data, dm_rsp_data;
  logic [13:0] mem_address;
  logic [31:0] mem_q = '0;

  text_memory_arbiter #(
    .STARVE_LIMIT (3),
    .MEM_AWIDTH   (14)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_address (if_req_address),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .if_rsp_error   (if_rsp_error),
    .dm_req_valid   (dm_req_valid),
    .dm_req_ready   (dm_req_ready),
    .dm_req_address (dm_req_address),
    .dm_rsp_valid   (dm_rsp_valid),
    .dm_rsp_data    (dm_rsp_data),
    .dm_rsp_error   (dm_rsp_error),
    .mem_address    (mem_address),
    .mem_q          (mem_q)
  );

  always #5 clock = ~clock;

  // Text memory contents: word 0 is a NOP, others carry their index.
  function automatic logic [31:0] memf(input logic [13:0] w);
    return (w == 14'd0) ? 32'h0000_0013 : (32'hc0de_0000 | {18'd0, w});
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
    return (a < TB_BEGIN) || (a > TB_END) || (a[1:0] != 2'b00);
  endfunction

  always @(posedge clock) mem_q <= memf(mem_address);

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] last_word = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per response pulse, and flags any expectation
  // whose cycle passes without a pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (if_rsp_valid) begin
        if (if_q.size() == 0) chk("if_rsp_unexpected", if_rsp_valid, 0);
        else begin
          e = if_q.pop_front();
          chk("if_rsp_cycle", cyc, e.cyc);
          chk("if_rsp_data", if_rsp_data, e.data);
          chk("if_rsp_error", if_rsp_error, e.err);
          chk("if_dm_exclusive", dm_rsp_valid, 0);
        end
      end else if (if_q.size() != 0 && if_q[0].cyc <= cyc) begin
        chk("if_rsp_missing", if_rsp_valid, 1);
        void'(if_q.pop_front());
      end
      if (dm_rsp_valid) begin
        if (dm_q.size() == 0) chk("dm_rsp_unexpected", dm_rsp_valid, 0);
        else begin
          e = dm_q.pop_front();
          chk("dm_rsp_cycle", cyc, e.cyc);
          chk("dm_rsp_data", dm_rsp_data, e.data);
          chk("dm_rsp_error", dm_rsp_error, e.err);
        end
      end else if (dm_q.size() != 0 && dm_q[0].cyc <= cyc) begin
        chk("dm_rsp_missing", dm_rsp_valid, 1);
        void'(dm_q.pop_front());
      end
    end
  end

  // One cycle of stimulus with the expected grant (GNONE/GIF/GDM).
  task automatic step(input logic iv, input logic [31:0] ia, input logic dv,
                      input logic [31:0] da, input int g);
    exp_t e;
    @(negedge clock);
    if_req_valid   = iv;
    if_req_address = ia;
    dm_req_valid   = dv;
    dm_req_address = da;
    #1;
    chk("if_req_ready", if_req_ready, (g == GIF) ? 1 : 0);
    chk("dm_req_ready", dm_req_ready, (g == GDM) ? 1 : 0);
    if (g != GNONE) begin
      e.err  = exp_err((g == GIF) ? ia : da);
      last_word = (g == GIF) ? ia[15:2] : da[15:2];
      e.data = e.err ? 32'h0 : memf(last_word);
      e.cyc  = cyc + 1;
      if (g == GIF) if_q.push_back(e);
      else dm_q.push_back(e);
    end
    chk("mem_address", mem_address, last_word);
  endtask

  // Pulses reset mid-cycle right after the previous handshake edge.
  task automatic reset_mid(input int starve_before);
    @(posedge clock);
    #1;
    chk("starve_before_reset", dut.starve_cnt_q, starve_before);
    #1;
    reset        = 1'b1;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    @(negedge clock);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_starve", dut.starve_cnt_q, 0);
    chk("rst_if_rsp_valid", if_rsp_valid, 0);
    chk("rst_dm_rsp_valid", dm_rsp_valid, 0);
    @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    last_word = '0;
    step(0, 0, 0, 0, GNONE);
    step(0, 0, 0, 0, GNONE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          order[10] = '{GDM, GDM, GDM, GIF, GDM, GDM, GDM, GIF, GDM, GDM};
  logic [31:0] ia, da;

  initial begin
    // Reset state, with both ports requesting to show ready stays low.
    if_req_valid = 1'b1;
    dm_req_valid = 1'b1;
    if_req_address = TB_BEGIN;
    dm_req_address = TB_BEGIN;
    @(negedge clock);
    chk("reset_if_ready", if_req_ready, 0);
    chk("reset_dm_ready", dm_req_ready, 0);
    chk("reset_if_rsp_valid", if_rsp_valid, 0);
    chk("reset_dm_rsp_valid", dm_rsp_valid, 0);
    chk("reset_if_rsp_error", if_rsp_error, 0);
    chk("reset_dm_rsp_data", dm_rsp_data, 0);
    chk("reset_mem_address", mem_address, 0);
    @(posedge clock);
    @(negedge clock);
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    reset = 1'b0;

    // Single fetch of word 0.
    step(1, TB_BEGIN, 0, 0, GIF);
    step(0, 0, 0, 0, GNONE);

    // Data loads at boundaries.
    step(0, 0, 1, TB_END + 1, GDM);
    step(0, 0, 1, TB_BEGIN + 2, GDM);
    step(0, 0, 1, TB_END, GDM);
    step(0, 0, 1, TB_BEGIN - 4, GDM);
    step(0, 0, 1, TB_END + 4, GDM);
    step(0, 0, 0, 0, GNONE);

    // Continuous contention: loser holds its address.
    ia = TB_BEGIN + 32'h40;
    da = TB_BEGIN + 32'h100;
    for (int i = 0; i < 10; i++) begin
      step(1, ia, 1, da, order[i]);
      if (order[i] == GDM) da += 4;
      else ia += 4;
    end
    // Third data grant after the last fetch: counter reaches the limit, then reset.
    step(1, ia, 1, da, GDM);
    void'(dm_q.pop_back());
    reset_mid(3);

    // Reset right after a fetch handshake drops the response.
    step(1, TB_BEGIN + 32'h20, 0, 0, GIF);
    void'(if_q.pop_back());
    reset_mid(0);
    step(1, TB_BEGIN + 32'h24, 0, 0, GIF);

    // Back-to-back fetches of words 0, 1, 2, then fetch alone keeps counter at 0.
    step(1, TB_BEGIN, 0, 0, GIF);
    step(1, TB_BEGIN + 4, 0, 0, GIF);
    step(1, TB_BEGIN + 8, 0, 0, GIF);
    for (int i = 0; i < 3; i++) begin
      step(1, TB_BEGIN + 32'h30 + 32'(4 * i), 0, 0, GIF);
      chk("starve_fetch_only", dut.starve_cnt_q, 0);
    end

    // Alternating ports, no bubble.
    step(1, TB_BEGIN + 32'h10, 0, 0, GIF);
    step(0, 0, 1, TB_BEGIN + 32'h14, GDM);
    step(1, TB_BEGIN + 32'h18, 0, 0, GIF);
    step(0, 0, 1, TB_BEGIN - 4, GDM);

    // Drain and hold check.
    step(0, 0, 0, 0, GNONE);
    step(0, 0, 0, 0, GNONE);
    chk("if_queue_drained", if_q.size(), 0);
    chk("dm_queue_drained", dm_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_memory_arbiter.md
# text_memory_arbiter

Shares the single-port, synchronous-read text memory between the instruction-fetch path and the data-load path, which reads constants and jump tables from the text segment. Accepts one request per cycle from either requester through valid/ready handshakes, range- and alignment-checks it, and drives the memory word address. One cycle later it returns the fetched word, or an error, to the requester that issued it. Sits between the core's fetch/load units and the text memory instance.

## Interface
- `STARVE_LIMIT`, 3: consecutive data grants allowed while fetch waits before fetch is forced.
- `MEM_AWIDTH`, 14: text memory word-address width; word address = `address[MEM_AWIDTH+1:2]`.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_req_valid` in 1: fetch request present.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_req_address` in 32: fetch byte address.
- `if_rsp_valid` out 1: fetch response valid, one cycle pulse.
- `if_rsp_data` out 32: fetched word; 0 on error.
- `if_rsp_error` out 1: out-of-range or misaligned.
- `dm_req_valid`, `dm_req_ready`, `dm_req_address`, `dm_rsp_valid`, `dm_rsp_data`, `dm_rsp_error`: same as the fetch port, for data loads.
- `mem_address` out MEM_AWIDTH: to text memory `address`.
- `mem_q` in 32: from text memory `q`, valid the cycle after the address edge.

## Operation
- Legal request: `TEXT_BEGIN <= address <= TEXT_END` and `address[1:0] == 0`. Otherwise the request is still accepted and completed with `rsp_error=1`, `rsp_data=0`, and no memory read is counted.
- Arbitration is combinational each cycle, with at most one grant per cycle. `ready` is asserted only to the granted port. A port must not wait for `ready` before asserting `valid`.
- Priority: data over fetch, except when `starve_cnt == STARVE_LIMIT` and `if_req_valid`, in which case fetch wins.
- `starve_cnt`: increments on a data grant while `if_req_valid=1`, saturating at STARVE_LIMIT. Clears on any fetch grant or any cycle with `if_req_valid=0`.
- `mem_address` follows the granted port's address. With no grant it holds the previous value; registered last-address, reset 0.
- In-flight register `{pend_valid, pend_port, pend_error}` is loaded on every accepted request.
- The next cycle, `pend_valid` raises `rsp_valid` on `pend_port` only. Data comes from `mem_q`, or 0 if `pend_error`.
- Responses have no backpressure; requesters must sink them.

## Timing
- Reset values: `pend_valid=0`, `starve_cnt=0`, last-address 0. Outputs: all `rsp_valid`/`rsp_error` 0, `rsp_data` 0, `mem_address` 0. Both `ready` are 0 while `reset=1`.
- Latency: request handshake at edge N gives the response during cycle N+1, sampled at edge N+1.
- Throughput: one request per cycle sustained. Back-to-back grants to alternating ports pipeline with no bubble.
- Simultaneous valid on both ports: exactly one `ready`; the loser holds `valid` and its address stable.
- Reset asserted mid-operation drops any in-flight response. No `rsp_valid` follows reset deassertion until a new handshake.
- Boundaries: `address == TEXT_END` with word alignment is legal. `TEXT_END+1`, `TEXT_END+4` and `TEXT_BEGIN-4` are errors.

## Structure
- Shared package or header holds `TEXT_BEGIN`/`TEXT_END` (existing defines), port-id encoding (`PORT_IF=0`, `PORT_DM=1`) and the response-tag struct.
- One natural sub-module: `text_request_checker`, a combinational range/alignment check instantiated per port. Arbiter, starvation counter and in-flight register stay in the top.

## Test plan
- Single fetch of `TEXT_BEGIN`, memory word 0 = 0x00000013: `if_req_ready=1` same cycle, next cycle `if_rsp_valid=1`, `if_rsp_data=0x00000013`, `if_rsp_error=0`, `dm_rsp_valid=0`.
- Both ports valid continuously for 10 cycles with STARVE_LIMIT=3: grant order D,D,D,I,D,D,D,I,D,D. Each response arrives one cycle after its grant on the correct port.
- Data load at `TEXT_END+1`: accepted, `dm_rsp_error=1`, `dm_rsp_data=0`. Load at `TEXT_BEGIN+2` (misaligned): error. Load at aligned `TEXT_END`: no error.
- Back-to-back fetches at `TEXT_BEGIN`, `+4`, `+8`: three consecutive `if_rsp_valid` pulses with words 0, 1, 2, no bubbles.
- `reset` pulsed asynchronously mid-cycle right after a fetch handshake: no `if_rsp_valid` afterward, `mem_address=0`, `starve_cnt=0`. The next request completes normally.
- Fetch valid alone while data idle: fetch granted every cycle and `starve_cnt` stays 0.
